// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//   Multicycle fetch/decode/execute controller for a CR16-style datapath.
//   It drives the ALU and register file and runs the memory interface. It also
//   latches the ALU flags into a PSR, which resolves conditional branches.
//
//   Instruction flow: FETCH -> DECODE -> EXEC (-> MEM for LOAD) -> FETCH.
//
//   Optional build macro: CPU_CONTROLLER_ILLEGAL_TRAP_EN
//     defined   : an illegal instruction parks the FSM in HALT (halted = 1,
//                 pc frozen, no writes) until reset.
//     undefined : illegal instructions execute as NOP and halted is tied to 0.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   memRdata            : memory read data, valid one cycle after memAddr
//   memAddr/memWe/memWdata : memory address, write strobe, write data
//   readData1/readData2 : R[srcAddr] / R[dstAddr] from the register file
//   aluOut, conds       : ALU result and flags {C,Z,E,L,F}
//   aluOp/aluIn1/aluIn2 : ALU operation select and operands
//   pcOut               : current program counter
//   srcAddr/dstAddr     : register read addresses (dstAddr is also write addr)
//   writeEn/writeData   : register file write port
//   psr                 : latched flags
//   halted              : illegal-instruction halt indicator
// -----------------------------------------------------------------------------
module cpu_controller #(
   parameter int               WIDTH    = 16,
   parameter int               NUMREGS  = 16,
   parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           memRdata,
   output logic [WIDTH-1:0]           memAddr,
   output logic                       memWe,
   output logic [WIDTH-1:0]           memWdata,
   input  logic [WIDTH-1:0]           readData1,
   input  logic [WIDTH-1:0]           readData2,
   input  logic [WIDTH-1:0]           aluOut,
   input  logic [4:0]                 conds,
   output logic [7:0]                 aluOp,
   output logic [WIDTH-1:0]           aluIn1,
   output logic [WIDTH-1:0]           aluIn2,
   output logic [WIDTH-1:0]           pcOut,
   output logic [$clog2(NUMREGS)-1:0] srcAddr,
   output logic [$clog2(NUMREGS)-1:0] dstAddr,
   output logic                       writeEn,
   output logic [WIDTH-1:0]           writeData,
   output logic [4:0]                 psr,
   output logic                       halted
);

   localparam int AW = $clog2(NUMREGS);

`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pc, ir;

   // Instruction fields
   logic [3:0] op, ext, cond;
   logic [7:0] imm8;
   assign op   = ir[15:12];
   assign cond = ir[11:8];
   assign ext  = ir[7:4];
   assign imm8 = ir[7:0];

   logic [WIDTH-1:0] imm_zext, imm_sext;
   assign imm_zext = {{(WIDTH-8){1'b0}}, imm8};
   assign imm_sext = {{(WIDTH-8){imm8[7]}}, imm8};

   // Decode (from IR, independent of state; state gates the side effects)
   logic             is_alu, alu_wr, is_load, is_stor, is_br, illegal;
   logic [7:0]       alu_op;
   logic [WIDTH-1:0] alu_b;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case statements can leave a latch behind.
      is_alu  = 1'b0;
      alu_wr  = 1'b0;
      is_load = 1'b0;
      is_stor = 1'b0;
      is_br   = 1'b0;
      alu_op  = 8'h00;
      alu_b   = readData1;
      case (op)
         4'b0000: begin
            if (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB}) begin
               is_alu = 1'b1;
               alu_op = {ext, 4'b0000};
               alu_wr = (ext != 4'b1011);   // CMP only updates flags
            end
         end
         4'b0001, 4'b0010, 4'b0011, 4'b0110: begin   // ANDI ORI XORI ADDUI
            is_alu = 1'b1;
            alu_op = {op, 4'b0000};
            alu_b  = imm_zext;
            alu_wr = 1'b1;
         end
         4'b0101, 4'b1001, 4'b1011: begin            // ADDI SUBI CMPI
            is_alu = 1'b1;
            alu_op = {op, 4'b0000};
            alu_b  = imm_sext;
            alu_wr = (op != 4'b1011);
         end
         4'b1000: begin                              // shifts
            is_alu = 1'b1;
            alu_op = {4'b1000, ext};
            alu_wr = 1'b1;
         end
         4'b0100: begin
            is_load = (ext == 4'b0000);
            is_stor = (ext == 4'b0100);
         end
         4'b1100: is_br = 1'b1;
         default: ;
      endcase
   end

   assign illegal = !(is_alu || is_load || is_stor || is_br);

   // Branch condition against latched flags {C,Z,E,L,F}
   logic br_taken;
   always_comb begin
      case (cond)
         4'b0000: br_taken = psr[2];
         4'b0001: br_taken = !psr[2];
         4'b1100: br_taken = psr[1];
         4'b1101: br_taken = !psr[1];
         4'b1110: br_taken = 1'b1;
         default: br_taken = 1'b0;
      endcase
   end

   logic [WIDTH-1:0] pc_inc, pc_br;
   assign pc_inc = pc + 1'b1;
   assign pc_br  = pc + imm_sext;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (is_load)                 state_nxt = S_MEM;
            else if (illegal && TRAP_EN) state_nxt = S_HALT;
            else                         state_nxt = S_FETCH;
         end
         S_MEM:    state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // PC, IR and PSR
   always_ff @(posedge clk) begin
      // NOTE: IR is reset as well so a fresh start never decodes stale bits
      // left from an aborted instruction.
      if (reset) begin
         pc  <= RESET_PC;
         ir  <= '0;
         psr <= '0;
      end else begin
         case (state)
            S_DECODE: ir <= memRdata;
            S_EXEC: begin
               if (is_alu) psr <= conds;
               if (is_br)
                  pc <= br_taken ? pc_br : pc_inc;
               else if (!is_load && !(illegal && TRAP_EN))
                  pc <= pc_inc;
            end
            S_MEM:   pc <= pc_inc;
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      memAddr   = pc;
      memWdata  = readData2;
      memWe     = 1'b0;
      writeEn   = 1'b0;
      writeData = aluOut;
      case (state)
         S_EXEC: begin
            if (is_load || is_stor) memAddr = readData1;
            memWe   = is_stor;
            writeEn = is_alu && alu_wr;
         end
         S_MEM: begin
            memAddr   = readData1;
            writeEn   = 1'b1;
            writeData = memRdata;
         end
         default: ;
      endcase
      // Reset aborts any in-flight instruction without side effects.
      if (reset) begin
         memWe   = 1'b0;
         writeEn = 1'b0;
      end
   end

   assign aluOp   = alu_op;
   assign aluIn1  = readData2;
   assign aluIn2  = alu_b;
   assign pcOut   = pc;
   assign srcAddr = ir[0 +: AW];
   assign dstAddr = ir[8 +: AW];

`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
   assign halted = (state == S_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//   Directed bench for cpu_controller. It surrounds the controller with a
//   synchronous memory, a register file and a small ALU. Register and memory
//   writes are predicted into a scoreboard queue; a monitor pops and compares
//   whenever writeEn or memWe is seen. Program flow (pc, psr, halted, reset
//   behaviour) is checked directly at fixed cycle points.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] memRdata, memAddr, memWdata;
   logic        memWe;
   logic [15:0] readData1, readData2, aluOut;
   logic [4:0]  conds;
   logic [7:0]  aluOp;
   logic [15:0] aluIn1, aluIn2, pcOut, writeData;
   logic [3:0]  srcAddr, dstAddr;
   logic        writeEn;
   logic [4:0]  psr;
   logic        halted;

   cpu_controller dut (
      .clk(clk), .reset(reset),
      .memRdata(memRdata), .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata),
      .readData1(readData1), .readData2(readData2),
      .aluOut(aluOut), .conds(conds),
      .aluOp(aluOp), .aluIn1(aluIn1), .aluIn2(aluIn2), .pcOut(pcOut),
      .srcAddr(srcAddr), .dstAddr(dstAddr),
      .writeEn(writeEn), .writeData(writeData),
      .psr(psr), .halted(halted)
   );

   always #5 clk = ~clk;

   // Environment: register file, memory, ALU
   logic [15:0] regs [0:15];
   logic [15:0] mem  [0:65535];
   logic        pl_reg_en = 1'b0, pl_mem_en = 1'b0;
   logic [3:0]  pl_reg_addr = '0;
   logic [15:0] pl_reg_data = '0, pl_mem_addr = '0, pl_mem_data = '0;

   assign readData1 = regs[srcAddr];
   assign readData2 = regs[dstAddr];

   always @(posedge clk) begin
      if (pl_reg_en)    regs[pl_reg_addr] <= pl_reg_data;
      else if (writeEn) regs[dstAddr]     <= writeData;
   end

   always @(posedge clk) begin
      if (pl_mem_en)  mem[pl_mem_addr] <= pl_mem_data;
      else if (memWe) mem[memAddr]     <= memWdata;
      memRdata <= mem[memAddr];
   end

   always_comb begin
      aluOut = 16'h0000;
      case (aluOp[7:4])
         4'h1:       aluOut = aluIn1 & aluIn2;
         4'h2:       aluOut = aluIn1 | aluIn2;
         4'h3:       aluOut = aluIn1 ^ aluIn2;
         4'h5, 4'h6: aluOut = aluIn1 + aluIn2;
         4'h9, 4'hB: aluOut = aluIn1 - aluIn2;
         4'h8:       aluOut = aluIn1 << aluIn2[3:0];
         default:    aluOut = 16'h0000;
      endcase
      conds = {1'b0, (aluOut == 16'h0000), (aluIn1 == aluIn2), (aluIn1 < aluIn2), 1'b0};
   end

   // Checking
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Scoreboard entries: {is_mem, addr[15:0], data[15:0]}
   logic [32:0] sb_q [$];

   task automatic expect_reg(input logic [3:0] a, input logic [15:0] d);
      sb_q.push_back({1'b0, 12'h000, a, d});
   endtask

   task automatic expect_mem(input logic [15:0] a, input logic [15:0] d);
      sb_q.push_back({1'b1, a, d});
   endtask

   task automatic observe(input string nm, input logic [32:0] act);
      int          n;
      logic [32:0] exp;
      n = sb_q.size();
      if (n == 0) begin
         check({nm, "_expected_pending"}, 64'(n), 64'd1);
      end else begin
         exp = sb_q.pop_front();
         check(nm, 64'(act), 64'(exp));
      end
   endtask

   always @(negedge clk) begin
      if (writeEn) observe("reg_write", {1'b0, 12'h000, dstAddr, writeData});
      if (memWe)   observe("mem_write", {1'b1, memAddr, memWdata});
   end

   // Stimulus helpers
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_reg(input logic [3:0] a, input logic [15:0] d);
      pl_reg_en = 1'b1; pl_reg_addr = a; pl_reg_data = d;
      step();
      pl_reg_en = 1'b0;
   endtask

   task automatic load_mem(input logic [15:0] a, input logic [15:0] d);
      pl_mem_en = 1'b1; pl_mem_addr = a; pl_mem_data = d;
      step();
      pl_mem_en = 1'b0;
   endtask

   task automatic begin_seg();
      reset = 1'b1;
      step(2);
   endtask

   initial begin
      // ---------------- reset state + R-type ADD ----------------
      begin_seg();
      load_reg(4'd1, 16'd3);
      load_reg(4'd2, 16'd3);
      load_mem(16'h0000, 16'h0152);         // ADD R1,R2
      check("reset_pc", 64'(pcOut), 64'h0000);
      check("reset_psr", 64'(psr), 64'h00);
      check("reset_halted", 64'(halted), 64'h0);
      check("reset_writeEn", 64'(writeEn), 64'h0);
      check("reset_memWe", 64'(memWe), 64'h0);
      expect_reg(4'd1, 16'd6);
      reset = 1'b0;
      step(2);                               // EXEC
      check("add_aluOp", 64'(aluOp), 64'h50);
      check("add_pc_exec", 64'(pcOut), 64'h0000);
      check("add_writeEn", 64'(writeEn), 64'h1);
      step(1);
      check("add_pc_after", 64'(pcOut), 64'h0001);
      check("add_r1", 64'(regs[1]), 64'h0006);
      check("add_psr", 64'(psr), 64'h04);    // E set, Z clear
      check("add_sb_drained", 64'(sb_q.size()), 64'd0);

      // ---------------- CMPI then BEQ taken ----------------
      begin_seg();
      load_reg(4'd6, 16'd1);
      load_mem(16'h0000, 16'hB601);         // CMPI R6,#1
      load_mem(16'h0001, 16'hC004);         // BEQ +4
      reset = 1'b0;
      step(3);
      check("cmpi_psr", 64'(psr), 64'h0C);   // Z and E
      check("cmpi_pc", 64'(pcOut), 64'h0001);
      step(3);
      check("beq_taken_pc", 64'(pcOut), 64'h0005);

      // ---------------- CMPI then BEQ not taken, BNE taken ----------------
      begin_seg();
      load_mem(16'h0000, 16'hB602);         // CMPI R6,#2
      load_mem(16'h0002, 16'hC103);         // BNE +3
      reset = 1'b0;
      step(3);
      check("cmpi_ne_psr", 64'(psr), 64'h02); // L only
      step(3);
      check("beq_not_taken_pc", 64'(pcOut), 64'h0002);
      step(3);
      check("bne_taken_pc", 64'(pcOut), 64'h0005);
      check("cmp_sb_drained", 64'(sb_q.size()), 64'd0);

      // ---------------- STOR / LOAD ----------------
      begin_seg();
      load_reg(4'd3, 16'h00AA);
      load_reg(4'd4, 16'h0010);
      load_reg(4'd5, 16'h0000);
      load_mem(16'h0000, 16'h4344);         // STOR R3,[R4]
      load_mem(16'h0001, 16'h4504);         // LOAD R5,[R4]
      expect_mem(16'h0010, 16'h00AA);
      expect_reg(4'd5, 16'h00AA);
      reset = 1'b0;
      step(2);
      check("stor_memWe", 64'(memWe), 64'h1);
      check("stor_memAddr", 64'(memAddr), 64'h0010);
      check("stor_memWdata", 64'(memWdata), 64'h00AA);
      step(1);
      check("stor_memWe_drop", 64'(memWe), 64'h0);
      check("stor_pc", 64'(pcOut), 64'h0001);
      step(3);                               // LOAD in MEM
      check("load_mem_writeEn", 64'(writeEn), 64'h1);
      check("load_mem_pc_held", 64'(pcOut), 64'h0001);
      step(1);
      check("load_pc", 64'(pcOut), 64'h0002);
      check("load_r5", 64'(regs[5]), 64'h00AA);
      check("ldst_psr_held", 64'(psr), 64'h00);
      check("ldst_sb_drained", 64'(sb_q.size()), 64'd0);

      // ---------------- PC wrap ----------------
      begin_seg();
      load_mem(16'h0000, 16'hCEFF);         // BUC -1
      load_mem(16'hFFFF, 16'hC200);         // never-taken branch (NOP)
      reset = 1'b0;
      step(3);
      check("wrap_back_pc", 64'(pcOut), 64'hFFFF);
      step(3);
      check("wrap_fwd_pc", 64'(pcOut), 64'h0000);

      // ---------------- reset during LOAD MEM ----------------
      begin_seg();
      load_reg(4'd4, 16'h0010);
      load_reg(4'd5, 16'h5555);
      load_mem(16'h0010, 16'h1234);
      load_mem(16'h0000, 16'hC200);         // NOP
      load_mem(16'h0001, 16'h4504);         // LOAD R5,[R4]
      reset = 1'b0;
      step(3);
      check("rst_pre_pc", 64'(pcOut), 64'h0001);
      step(3);                               // LOAD in MEM
      reset = 1'b1;
      #1;
      check("rst_mid_writeEn", 64'(writeEn), 64'h0);
      step(1);
      check("rst_mid_r5", 64'(regs[5]), 64'h5555);
      check("rst_mid_pc", 64'(pcOut), 64'h0000);
      reset = 1'b0;
      step(3);
      check("rst_restart_pc", 64'(pcOut), 64'h0001);

      // ---------------- immediates and R-type CMP ----------------
      begin_seg();
      load_reg(4'd7, 16'h0005);
      load_reg(4'd8, 16'hFFFF);
      load_mem(16'h0000, 16'h57FF);         // ADDI R7,#-1
      load_mem(16'h0001, 16'h18F0);         // ANDI R8,#F0 (zero-extended)
      load_mem(16'h0002, 16'h07B8);         // CMP R7,R8
      expect_reg(4'd7, 16'h0004);
      expect_reg(4'd8, 16'h00F0);
      reset = 1'b0;
      step(6);
      check("addi_r7", 64'(regs[7]), 64'h0004);
      check("andi_r8", 64'(regs[8]), 64'h00F0);
      step(3);
      check("cmp_psr", 64'(psr), 64'h02);
      check("cmp_pc", 64'(pcOut), 64'h0003);
      check("imm_sb_drained", 64'(sb_q.size()), 64'd0);

      // ---------------- illegal op ----------------
      begin_seg();
      load_mem(16'h0000, 16'hF000);
      reset = 1'b0;
      step(3);
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
      check("trap_halted", 64'(halted), 64'h1);
      check("trap_pc", 64'(pcOut), 64'h0000);
      step(10);
      check("trap_pc_frozen", 64'(pcOut), 64'h0000);
      check("trap_still_halted", 64'(halted), 64'h1);
      reset = 1'b1;
      step(1);
      check("trap_cleared", 64'(halted), 64'h0);
`else
      check("illegal_pc", 64'(pcOut), 64'h0001);
      check("illegal_halted", 64'(halted), 64'h0);
      check("illegal_psr_held", 64'(psr), 64'h00);
`endif
      check("final_sb_drained", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
